// File: rtl/sprite_blit_pkg.sv
// Shared definitions for the sprite blitter: directions, FSM states,
// sprite ROM word layout and the diagonal sprite base offset.
package sprite_blit_pkg;

  // Directions, counter-clockwise from east. Even = straight, odd = diagonal.
  localparam logic [2:0] DIR_E  = 3'd0;
  localparam logic [2:0] DIR_UR = 3'd1;
  localparam logic [2:0] DIR_N  = 3'd2;
  localparam logic [2:0] DIR_UL = 3'd3;
  localparam logic [2:0] DIR_W  = 3'd4;
  localparam logic [2:0] DIR_DL = 3'd5;
  localparam logic [2:0] DIR_S  = 3'd6;
  localparam logic [2:0] DIR_DR = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int PIX_COL_W = 9;

  // Sprite ROM word: opaque flag above the {R,G,B} colour.
  typedef struct packed {
    logic                 opaque;
    logic [PIX_COL_W-1:0] colour;
  } pixel_t;

  // Diagonal sprites are stored directly after the straight sprite.
  function automatic int diag_base(input int sw, input int sh);
    return sw * sh;
  endfunction

endpackage

// File: rtl/sprite_coord_gen.sv
// Walks the sprite index with incremental row/col counters, maps each
// index to screen coordinates for the job direction and flags clipping.
// Outputs are registered: the index loaded or advanced at an edge is
// visible on the outputs in the following cycle.
module sprite_coord_gen
  import sprite_blit_pkg::*;
#(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int ADDR_W   = 15,
  parameter int SW       = 8,
  parameter int SH       = 14,
  parameter int DG       = 15,
  parameter int SA_W     = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [X_W-1:0]    base_x,
  input  logic [Y_W-1:0]    base_y,
  input  logic [2:0]        dir,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [SA_W-1:0]   spr_addr,
  output logic [ADDR_W-1:0] bg_addr,
  output logic              valid,
  output logic              last
);

  localparam int XW1 = X_W + 1;
  localparam int YW1 = Y_W + 1;
  localparam logic [SA_W-1:0] SW_L      = SA_W'(SW);
  localparam logic [SA_W-1:0] DG_L      = SA_W'(DG);
  localparam logic [SA_W-1:0] LAST_ST   = SA_W'(SW * SH - 1);
  localparam logic [SA_W-1:0] LAST_DG   = SA_W'(DG * DG - 1);
  localparam logic [SA_W-1:0] DIAG_BASE = SA_W'(diag_base(SW, SH));

  logic [SA_W-1:0]   idx_r, row_r, col_r;
  logic              act_r;
  logic [SA_W-1:0]   idx_n, row_n, col_n, width_s;
  logic              act_n, clip_s, vis_s;
  logic [XW1-1:0]    x_n;
  logic [YW1-1:0]    y_n;
  logic [ADDR_W-1:0] bg_n;
  logic [SA_W-1:0]   spr_n;

  assign width_s = dir[0] ? DG_L : SW_L;
  assign last    = act_r && (idx_r == (dir[0] ? LAST_DG : LAST_ST));

  // Next index/row/col: restart on load, step with column wrap on advance.
  always_comb begin
    idx_n = '0;
    row_n = '0;
    col_n = '0;
    act_n = 1'b0;
    if (load) begin
      act_n = 1'b1;
    end else if (advance) begin
      act_n = 1'b1;
      idx_n = idx_r + SA_W'(1);
      if (col_r == width_s - SA_W'(1)) begin
        col_n = '0;
        row_n = row_r + SA_W'(1);
      end else begin
        col_n = col_r + SA_W'(1);
        row_n = row_r;
      end
    end else begin
      act_n = 1'b0;
    end
  end

  // Direction mapping, clip test and memory addresses for the next index.
  always_comb begin
    case (dir)
      DIR_N, DIR_S: begin
        x_n = {1'b0, base_x} + XW1'(col_n);
        y_n = {1'b0, base_y} + YW1'(row_n);
      end
      DIR_E, DIR_W: begin
        x_n = {1'b0, base_x} + XW1'(row_n);
        y_n = {1'b0, base_y} + YW1'(col_n);
      end
      DIR_UL, DIR_DR: begin
        x_n = {1'b0, base_x} + XW1'(col_n);
        y_n = {1'b0, base_y} + YW1'(row_n);
      end
      default: begin
        x_n = {1'b0, base_x} + XW1'(DG - 1) - XW1'(col_n);
        y_n = {1'b0, base_y} + YW1'(row_n);
      end
    endcase
    clip_s = (x_n >= XW1'(SCREEN_W)) || (y_n >= YW1'(SCREEN_H));
    vis_s  = act_n && !clip_s;
    if (vis_s) begin
      bg_n = ADDR_W'(x_n) + ADDR_W'(SCREEN_W) * ADDR_W'(y_n);
    end else begin
      bg_n = '0;
    end
    if (!act_n) begin
      spr_n = '0;
    end else if (dir[0]) begin
      spr_n = DIAG_BASE + idx_n;
    end else begin
      spr_n = idx_n;
    end
  end

  // Counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r    <= '0;
      row_r    <= '0;
      col_r    <= '0;
      act_r    <= 1'b0;
      x        <= '0;
      y        <= '0;
      spr_addr <= '0;
      bg_addr  <= '0;
      valid    <= 1'b0;
    end else begin
      idx_r    <= idx_n;
      row_r    <= row_n;
      col_r    <= col_n;
      act_r    <= act_n;
      x        <= X_W'(x_n);
      y        <= Y_W'(y_n);
      spr_addr <= spr_n;
      bg_addr  <= bg_n;
      valid    <= vis_s;
    end
  end

endmodule

// File: rtl/sprite_blit.sv
// Sprite blitter top: job FSM, coordinate generator, a pipe that keeps
// pixel position/plot/erase aligned with the memory read latency, and the
// sprite-versus-background colour select.
module sprite_blit
  import sprite_blit_pkg::*;
#(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int ADDR_W   = 15,
  parameter int COL_W    = 9,
  parameter int SW       = 8,
  parameter int SH       = 14,
  parameter int DG       = 15,
  parameter int RD_LAT   = 2,
  localparam int SA_W    = $clog2(SW * SH + DG * DG)
) (
  input  logic              iClock,
  input  logic              iResetn,
  input  logic              iStart,
  input  logic [X_W-1:0]    iX,
  input  logic [Y_W-1:0]    iY,
  input  logic [2:0]        iDir,
  input  logic              iErase,
  output logic [SA_W-1:0]   oSprAddr,
  input  logic [COL_W:0]    iSprPix,
  output logic [ADDR_W-1:0] oBgAddr,
  input  logic [COL_W-1:0]  iBgCol,
  output logic [X_W-1:0]    oX,
  output logic [Y_W-1:0]    oY,
  output logic [COL_W-1:0]  oColour,
  output logic              oPlot,
  output logic              oBusy,
  output logic              oDone,
  output logic [X_W-1:0]    oRX,
  output logic [Y_W-1:0]    oRY,
  output logic [2:0]        oRdir
);

  localparam int DC_W = $clog2(RD_LAT + 1);

  state_t          state_r, state_n;
  logic [DC_W-1:0] drain_r;
  logic            start_s, last_s, advance_s;
  logic [X_W-1:0]  rx_r;
  logic [Y_W-1:0]  ry_r;
  logic [2:0]      rdir_r;
  logic            rerase_r, busy_r, done_r;
  logic [X_W-1:0]  cg_x;
  logic [Y_W-1:0]  cg_y;
  logic            cg_valid;
  logic [X_W-1:0]  px_r [RD_LAT];
  logic [Y_W-1:0]  py_r [RD_LAT];
  logic            pv_r [RD_LAT];
  logic            pe_r [RD_LAT];
  logic [COL_W-1:0] colour_s;

  // Next-state logic; the start request is only honoured in IDLE.
  always_comb begin
    state_n = state_r;
    start_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (iStart) begin
          state_n = SCAN;
          start_s = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      SCAN: begin
        if (last_s) state_n = DRAIN;
        else        state_n = SCAN;
      end
      DRAIN: begin
        if (drain_r == DC_W'(RD_LAT - 1)) state_n = DONE;
        else                              state_n = DRAIN;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign advance_s = (state_r == SCAN) && !last_s;

  // State register, job capture and registered status flags.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      state_r  <= IDLE;
      drain_r  <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      rx_r     <= '0;
      ry_r     <= '0;
      rdir_r   <= '0;
      rerase_r <= 1'b0;
    end else begin
      state_r <= state_n;
      busy_r  <= (state_n != IDLE);
      done_r  <= (state_n == DONE);
      drain_r <= (state_r == DRAIN) ? drain_r + DC_W'(1) : '0;
      if (start_s) begin
        rx_r     <= iX;
        ry_r     <= iY;
        rdir_r   <= iDir;
        rerase_r <= iErase;
      end
    end
  end

  // The first index is generated from the live inputs at the start edge;
  // later indices use the captured job so input changes mid-job are ignored.
  sprite_coord_gen #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .X_W      (X_W),
    .Y_W      (Y_W),
    .ADDR_W   (ADDR_W),
    .SW       (SW),
    .SH       (SH),
    .DG       (DG),
    .SA_W     (SA_W)
  ) u_coord (
    .clk      (iClock),
    .rst_n    (iResetn),
    .load     (start_s),
    .advance  (advance_s),
    .base_x   (start_s ? iX : rx_r),
    .base_y   (start_s ? iY : ry_r),
    .dir      (start_s ? iDir : rdir_r),
    .x        (cg_x),
    .y        (cg_y),
    .spr_addr (oSprAddr),
    .bg_addr  (oBgAddr),
    .valid    (cg_valid),
    .last     (last_s)
  );

  // Pixel pipe matching the memory read latency; the last stage drives the VGA port.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      for (int j = 0; j < RD_LAT; j++) begin
        px_r[j] <= '0;
        py_r[j] <= '0;
        pv_r[j] <= 1'b0;
        pe_r[j] <= 1'b0;
      end
    end else begin
      px_r[0] <= cg_x;
      py_r[0] <= cg_y;
      pv_r[0] <= cg_valid;
      pe_r[0] <= rerase_r;
      for (int j = 1; j < RD_LAT; j++) begin
        px_r[j] <= px_r[j-1];
        py_r[j] <= py_r[j-1];
        pv_r[j] <= pv_r[j-1];
        pe_r[j] <= pe_r[j-1];
      end
    end
  end

  // Colour select on the memory data arriving with the pipe's last stage;
  // held at zero whenever no pixel is being plotted.
  always_comb begin
    if (!pv_r[RD_LAT-1]) begin
      colour_s = '0;
    end else if (iSprPix[COL_W] && !pe_r[RD_LAT-1]) begin
      colour_s = iSprPix[COL_W-1:0];
    end else begin
      colour_s = iBgCol;
    end
  end

  assign oX      = px_r[RD_LAT-1];
  assign oY      = py_r[RD_LAT-1];
  assign oPlot   = pv_r[RD_LAT-1];
  assign oColour = colour_s;
  assign oBusy   = busy_r;
  assign oDone   = done_r;
  assign oRX     = rx_r;
  assign oRY     = ry_r;
  assign oRdir   = rdir_r;

endmodule

// File: tb/tb_sprite_blit.sv
// Directed bench for sprite_blit with a scoreboard of expected plots.
// Memories are modelled as RD_LAT register stages from address to data.
module tb_sprite_blit;
  import sprite_blit_pkg::*;

  localparam int RD_LAT = 2;
  localparam int SW = 8, SH = 14, DG = 15;

  typedef struct packed {
    int         cyc;
    logic [7:0] x;
    logic [6:0] y;
    logic [8:0] col;
  } exp_t;

  logic        iClock = 1'b0, iResetn = 1'b0, iStart = 1'b0, iErase = 1'b0;
  logic [7:0]  iX = 8'd0;
  logic [6:0]  iY = 7'd0;
  logic [2:0]  iDir = 3'd0;
  logic [8:0]  oSprAddr;
  logic [9:0]  iSprPix;
  logic [14:0] oBgAddr;
  logic [8:0]  iBgCol;
  logic [7:0]  oX, oRX;
  logic [6:0]  oY, oRY;
  logic [8:0]  oColour;
  logic        oPlot, oBusy, oDone;
  logic [2:0]  oRdir;

  int   checks = 0, failures = 0;
  int   cyc = 0, t0 = 0, exp_done = -1;
  logic all_opaque = 1'b0;
  exp_t sb[$];

  pixel_t     spr_q [RD_LAT];
  logic [8:0] bg_q  [RD_LAT];

  sprite_blit dut (
    .iClock(iClock), .iResetn(iResetn), .iStart(iStart), .iX(iX), .iY(iY),
    .iDir(iDir), .iErase(iErase), .oSprAddr(oSprAddr), .iSprPix(iSprPix),
    .oBgAddr(oBgAddr), .iBgCol(iBgCol), .oX(oX), .oY(oY), .oColour(oColour),
    .oPlot(oPlot), .oBusy(oBusy), .oDone(oDone), .oRX(oRX), .oRY(oRY), .oRdir(oRdir)
  );

  always #5 iClock = ~iClock;

  // Cycle counter: value seen during the period after each rising edge.
  always @(posedge iClock) cyc <= cyc + 1;

  // Sprite ROM (colour = index, opaque on even index) and background map (colour = addr[8:0]).
  always @(posedge iClock) begin
    spr_q[0] <= '{opaque: (all_opaque | ~oSprAddr[0]), colour: oSprAddr};
    bg_q[0]  <= oBgAddr[8:0];
    for (int j = 1; j < RD_LAT; j++) begin
      spr_q[j] <= spr_q[j-1];
      bg_q[j]  <= bg_q[j-1];
    end
  end
  assign iSprPix = spr_q[RD_LAT-1];
  assign iBgCol  = bg_q[RD_LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Plot and done monitor, sampled on the falling edge.
  always @(negedge iClock) begin
    exp_t e;
    if (oDone) chk("done_cycle", cyc, exp_done);
    if (iResetn && oPlot) begin
      chk("plot_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("plot_cycle", cyc, e.cyc);
        chk("plot_x", 32'(oX), 32'(e.x));
        chk("plot_y", 32'(oY), 32'(e.y));
        chk("plot_colour", 32'(oColour), 32'(e.col));
      end
    end
  end

  // Drive a start pulse and push every expected on-screen pixel.
  task automatic start_job(input int x, input int y, input int dir, input int erase);
    int n, w, row, col, px, py, s, c;
    @(negedge iClock);
    iX = 8'(x); iY = 7'(y); iDir = 3'(dir); iErase = 1'(erase); iStart = 1'b1;
    @(negedge iClock);
    iStart = 1'b0;
    t0 = cyc;
    n = dir[0] ? DG * DG : SW * SH;
    w = dir[0] ? DG : SW;
    for (int i = 0; i < n; i++) begin
      row = i / w;
      col = i % w;
      s = dir[0] ? SW * SH + i : i;
      case (dir)
        0, 4:    begin px = x + row;          py = y + col; end
        1, 5:    begin px = x + DG - 1 - col; py = y + row; end
        default: begin px = x + col;          py = y + row; end
      endcase
      if (px < 160 && py < 120) begin
        if ((all_opaque || (s % 2 == 0)) && erase == 0) c = s % 512;
        else c = (px + 160 * py) % 512;
        sb.push_back('{cyc: t0 + i + RD_LAT, x: 8'(px), y: 7'(py), col: 9'(c)});
      end
    end
    exp_done = t0 + n + RD_LAT;
  endtask

  // Bounded wait for oDone, then status and scoreboard drain checks.
  task automatic finish_job();
    int budget = 400;
    while (!oDone && budget > 0) begin
      @(negedge iClock);
      budget--;
    end
    chk("done_seen", 32'(oDone), 32'd1);
    chk("busy_at_done", 32'(oBusy), 32'd1);
    @(negedge iClock);
    chk("busy_after_done", 32'(oBusy), 32'd0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge iClock);
    chk("rst_busy", 32'(oBusy), 32'd0);
    chk("rst_done", 32'(oDone), 32'd0);
    chk("rst_plot", 32'(oPlot), 32'd0);
    chk("rst_spr_addr", 32'(oSprAddr), 32'd0);
    chk("rst_bg_addr", 32'(oBgAddr), 32'd0);
    chk("rst_rx", 32'(oRX), 32'd0);
    chk("rst_ry", 32'(oRY), 32'd0);
    chk("rst_rdir", 32'(oRdir), 32'd0);
    iResetn = 1'b1;
    repeat (2) @(negedge iClock);

    // Straight draw, Rdir=2 at (10,20)
    start_job(10, 20, 2, 0);
    chk("capture_rx", 32'(oRX), 32'd10);
    chk("capture_ry", 32'(oRY), 32'd20);
    chk("capture_rdir", 32'(oRdir), 32'd2);
    chk("busy_after_start", 32'(oBusy), 32'd1);
    chk("spr_addr_i0", 32'(oSprAddr), 32'd0);
    chk("bg_addr_i0", 32'(oBgAddr), 32'd3210);
    repeat (5) @(negedge iClock);
    chk("spr_addr_i5", 32'(oSprAddr), 32'd5);
    chk("bg_addr_i5", 32'(oBgAddr), 32'd3215);
    finish_job();

    // Transposed draw, Rdir=0 at (10,20)
    start_job(10, 20, 0, 0);
    finish_job();

    // Mirrored diagonal with clipping, Rdir=1 at (150,110)
    start_job(150, 110, 1, 0);
    chk("diag_spr_addr_i0", 32'(oSprAddr), 32'd112);
    chk("clipped_bg_addr_i0", 32'(oBgAddr), 32'd0);
    finish_job();

    // Erase over an all-opaque sprite, Rdir=3
    all_opaque = 1'b1;
    start_job(40, 30, 3, 1);
    finish_job();
    all_opaque = 1'b0;

    // Start request and input changes while busy are ignored
    start_job(20, 10, 6, 0);
    repeat (49) @(negedge iClock);
    iStart = 1'b1; iX = 8'd90; iY = 7'd5; iDir = 3'd1;
    @(negedge iClock);
    iStart = 1'b0;
    finish_job();
    chk("rx_kept", 32'(oRX), 32'd20);
    repeat (20) @(negedge iClock);
    chk("no_second_job", 32'(oBusy), 32'd0);

    // Reset mid-job: outputs clear at once, no done, then a clean job
    start_job(5, 5, 2, 0);
    repeat (39) @(negedge iClock);
    #2;
    iResetn = 1'b0;
    exp_done = -1;
    #1;
    chk("midrst_busy", 32'(oBusy), 32'd0);
    chk("midrst_plot", 32'(oPlot), 32'd0);
    chk("midrst_x", 32'(oX), 32'd0);
    chk("midrst_y", 32'(oY), 32'd0);
    chk("midrst_colour", 32'(oColour), 32'd0);
    chk("midrst_spr_addr", 32'(oSprAddr), 32'd0);
    chk("midrst_bg_addr", 32'(oBgAddr), 32'd0);
    chk("midrst_rx", 32'(oRX), 32'd0);
    chk("midrst_rdir", 32'(oRdir), 32'd0);
    sb.delete();
    repeat (3) @(negedge iClock);
    iResetn = 1'b1;
    repeat (10) @(negedge iClock);
    chk("post_rst_idle", 32'(oBusy), 32'd0);
    start_job(100, 50, 7, 0);
    finish_job();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_blit.md
# sprite_blit

Parametrised sprite blitter for the VGA game path. It draws one oriented sprite (straight or diagonal variant, 8 directions) at a screen position, one pixel per clock. Each pixel's colour comes from either the sprite, where the pixel is opaque, or the background map memory, where it is transparent. It clips pixels that fall off-screen and has an erase mode that restores background only. It sits between the game FSM (start/position/direction) and the VGA adapter (oX/oY/oColour/oPlot), with read ports to an external sprite ROM and the background map memory.

## Interface
- SCREEN_W, 160, screen width in pixels
- SCREEN_H, 120, screen height in pixels
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- ADDR_W, 15, background address width
- COL_W, 9, colour width ({R,G,B}, COL_W/3 bits each)
- SW, 8, straight sprite width (columns)
- SH, 14, straight sprite height (rows)
- DG, 15, diagonal sprite side (DG×DG)
- RD_LAT, 2, read latency of both memories, in cycles (≥1)
- iClock in 1: clock
- iResetn in 1: reset, asynchronous, active-low
- iStart in 1: start request; sampled only in IDLE
- iX in X_W, iY in Y_W: upper-left corner of the bounding box
- iDir in 3: direction; even = straight, odd = diagonal
- iErase in 1: 1 = draw background only (erase)
- oSprAddr out clog2(SW*SH+DG*DG): sprite ROM index
- iSprPix in COL_W+1: {opaque, colour}, valid RD_LAT cycles after oSprAddr
- oBgAddr out ADDR_W: x + SCREEN_W*y
- iBgCol in COL_W: background colour, valid RD_LAT cycles after oBgAddr
- oX out X_W, oY out Y_W, oColour out COL_W, oPlot out 1: pixel write to the VGA adapter
- oBusy out 1, oDone out 1: status
- oRX out X_W, oRY out Y_W, oRdir out 3: captured job registers

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE, iStart=1 at an edge: capture iX, iY, iDir, iErase into RX/RY/Rdir/Rerase; go to SCAN. No other state samples iStart.
- SCAN: a linear index i runs 0..N-1, one per cycle.
  - N = SW*SH for even Rdir; N = DG*DG for odd Rdir.
  - Go to DRAIN after i = N-1.
- DRAIN: RD_LAT cycles, then DONE. DONE lasts 1 cycle, then IDLE.
- Straight geometry: row = i / SW, col = i % SW, sprite index = i.
  - Rdir 2 or 6: x = RX+col, y = RY+row.
  - Rdir 0 or 4: x = RX+row, y = RY+col (transposed).
- Diagonal geometry: row = i / DG, col = i % DG, sprite index = SW*SH + i.
  - Rdir 3 or 7: x = RX+col.
  - Rdir 1 or 5: x = RX+DG-1-col.
  - In both cases y = RY+row.
- Coordinate sums use X_W+1 / Y_W+1 bits. A pixel is clipped if x ≥ SCREEN_W or y ≥ SCREEN_H. A clipped pixel produces no oPlot, and oBgAddr is driven to 0 for it.
- Colour select: opaque && !Rerase → sprite colour; otherwise iBgCol.
- The row/col counters are incremental; no divider is allowed.

## Timing
- Reset, asynchronous: state IDLE; every output 0, including oRX/oRY/oRdir, oSprAddr, oBgAddr.
- Start: iStart seen at edge k → oBusy=1 from cycle k+1.
- Addresses: index i is driven on oSprAddr/oBgAddr in cycle k+1+i.
- Plot: pixel i is presented on oX/oY/oColour/oPlot (registered) in cycle k+1+i+RD_LAT.
- Throughput: one pixel per clock; no gaps, including around clipped pixels.
- Done: oDone is a 1-cycle pulse in cycle k+1+N+RD_LAT, with oBusy still 1. oBusy=0 from the next cycle.
- Back-to-back: the earliest next start is sampled in the cycle after DONE.
- iStart while busy is ignored and not queued.
- Input changes: changes to iX/iY/iDir during a job have no effect.
- Reset mid-job: drawing aborts immediately, no oDone, and in-flight pixels are dropped.

## Structure
- sprite_blit_pkg holds:
  - direction constants DIR_E=0 … DIR_DR=7
  - state enum
  - pixel typedef {opaque, colour}
  - the diagonal base-offset function
- Submodule sprite_coord_gen contains the index, row and col counters, the direction mapping and the clip flag, producing registered {x, y, index, valid}.
- The top level contains the FSM, a RD_LAT-deep shift pipe carrying {x, y, valid, Rerase} alongside the memory reads, and the colour mux.

## Test plan
- Straight draw: Rdir=2 at (10,20), ROM colour = index, opaque = index even. Expect 112 plots over x 10..17, y 20..33. Odd indices show iBgCol = addr[8:0]. oDone at k+115.
- Transposed draw: Rdir=0 at (10,20). Expect pixel i=9 at (11,21) and i=8 at (11,20). The bounding box is 14 wide and 8 tall.
- Mirrored diagonal with clipping: Rdir=1 at (150,110). Expect i=0 (x=164) and any pixel with y ≥ 120 to have oPlot=0. Expect (150,110) plotted for i=14. oDone still at k+1+225+2.
- Erase: iErase=1, Rdir=3, all sprite pixels opaque. Expect every oColour to equal iBgCol.
- Start while busy: pulse iStart at k+50 with a different iX. Expect the first job unchanged and no second job.
- Reset mid-job: assert iResetn=0 at k+40. Expect all outputs 0 asynchronously, no oDone, and a clean new job after a subsequent start.
